// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port memory: 1-cycle grant, then waits on mem_ready; data wins unless fetch hit STARVE_LIMIT.
// Requesters hold req until their one-cycle ready pulse; optional grant counters under MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_if_grants,
  output logic [15:0]       stat_d_grants,
  output logic [7:0]        stat_forced
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            r_state;
  logic [3:0]        r_starve_cnt;
  logic              r_mem_valid;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_idle;
  logic w_dreq;
  logic w_force;
  logic w_grant_i;
  logic w_grant_d;
  logic w_if_ready;
  logic w_d_ready;

  assign w_idle    = (r_state == IDLE);
  assign w_dreq    = d_rd | d_wr;
  assign w_force   = if_req & w_dreq & (r_starve_cnt == LIMIT);
  assign w_grant_i = w_idle & if_req & (~w_dreq | w_force);
  assign w_grant_d = w_idle & w_dreq & ~w_grant_i;

  // Gated by rst_n so a memory completion during reset never reaches a requester.
  assign w_if_ready = rst_n & (r_state == BUSY_I) & mem_ready;
  assign w_d_ready  = rst_n & (r_state == BUSY_D) & mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state      <= BUSY_I;
            r_mem_valid  <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_starve_cnt <= 4'd0;
          end else if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_mem_valid <= 1'b1;
            r_mem_we    <= d_wr;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            // Only a data win over a waiting fetch counts toward starvation.
            if (if_req) r_starve_cnt <= r_starve_cnt + 4'd1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ready  = w_if_ready;
  assign d_ready   = w_d_ready;
  assign if_rdata  = w_if_ready ? mem_rdata : '0;
  assign d_rdata   = w_d_ready  ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_stat_if;
  logic [15:0] r_stat_d;
  logic [7:0]  r_stat_forced;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_if     <= 16'd0;
      r_stat_d      <= 16'd0;
      r_stat_forced <= 8'd0;
    end else begin
      if (w_grant_i && !(&r_stat_if))            r_stat_if     <= r_stat_if + 16'd1;
      if (w_grant_d && !(&r_stat_d))             r_stat_d      <= r_stat_d + 16'd1;
      if (w_idle && w_force && !(&r_stat_forced)) r_stat_forced <= r_stat_forced + 8'd1;
    end
  end

  assign stat_if_grants = r_stat_if;
  assign stat_d_grants  = r_stat_d;
  assign stat_forced    = r_stat_forced;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic vs a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_if_grants;
  logic [15:0] stat_d_grants;
  logic [7:0]  stat_forced;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants), .stat_forced(stat_forced)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding access, owner, and how many
  // times in a row data has beaten a waiting fetch.
  logic        m_busy = 1'b0;
  logic        m_own_d = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_we = 1'b0;
  int          m_run = 0;
  int          m_ifg = 0, m_dg = 0, m_forced = 0;
  bit          m_log[$];
  bit          dut_log[$];
  bit          log_en = 1'b0;
  bit          chk_en = 1'b0;
  bit          saw_if_rdy = 1'b0, saw_d_rdy = 1'b0;
  int          n_if_rdy = 0, n_d_rdy = 0;

  always @(posedge clk) begin
    bit dreq, fetch_wins;
    dreq = d_rd | d_wr;
    if (!rst_n) begin
      m_busy = 0; m_run = 0; m_addr = 0; m_wdata = 0; m_we = 0;
      m_ifg = 0; m_dg = 0; m_forced = 0;
    end else if (m_busy) begin
      if (mem_ready) m_busy = 0;
    end else if (if_req || dreq) begin
      fetch_wins = if_req && (!dreq || m_run == LIM);
      if (fetch_wins) begin
        m_own_d = 0; m_addr = if_addr; m_we = 0; m_run = 0;
        if (m_ifg < 16'hFFFF) m_ifg++;
        if (dreq && m_forced < 8'hFF) m_forced++;
      end else begin
        m_own_d = 1; m_addr = d_addr; m_wdata = d_wdata; m_we = d_wr;
        if (if_req) m_run++;
        if (m_dg < 16'hFFFF) m_dg++;
      end
      m_busy = 1;
      if (log_en) m_log.push_back(fetch_wins);
    end
  end

  always @(negedge clk) begin
    logic e_if, e_d;
    saw_if_rdy = if_ready;
    saw_d_rdy  = d_ready;
    if (chk_en) begin
      e_if = rst_n && m_busy && !m_own_d && mem_ready;
      e_d  = rst_n && m_busy &&  m_own_d && mem_ready;
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, m_busy});
      chk("if_ready", {31'd0, if_ready}, {31'd0, e_if});
      chk("d_ready", {31'd0, d_ready}, {31'd0, e_d});
      chk("if_rdata", if_rdata, e_if ? mem_rdata : 32'd0);
      chk("d_rdata", d_rdata, e_d ? mem_rdata : 32'd0);
      if (m_busy) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
`ifdef MEM_ARB_STATS_EN
      chk("stat_if_grants", {16'd0, stat_if_grants}, m_ifg);
      chk("stat_d_grants", {16'd0, stat_d_grants}, m_dg);
      chk("stat_forced", {24'd0, stat_forced}, m_forced);
`endif
      if (if_ready) n_if_rdy++;
      if (d_ready) n_d_rdy++;
      if (log_en && if_ready) dut_log.push_back(1'b1);
      if (log_en && d_ready) dut_log.push_back(1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 0; if_req = 0; d_rd = 0; d_wr = 0; mem_ready = 0;
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    bit exp_pat[10];
    int p_if, p_d;
    exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    do_reset();
    chk_en = 1;
    @(negedge clk);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);

    // Fetch only, memory latency 3.
    step(); if_req = 1; if_addr = 32'h100;
    @(negedge clk); chk("f_c0_valid", {31'd0, mem_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("f_c1_valid", {31'd0, mem_valid}, 32'd1);
    chk("f_c1_addr", mem_addr, 32'h100);
    chk("f_c1_we", {31'd0, mem_we}, 32'd0);
    step();
    step(); mem_ready = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("f_c3_if_ready", {31'd0, if_ready}, 32'd1);
    chk("f_c3_if_rdata", if_rdata, 32'h1234_5678);
    step(); if_req = 0; mem_ready = 0;
    @(negedge clk);
    chk("f_c4_valid", {31'd0, mem_valid}, 32'd0);
    chk("f_c4_if_ready", {31'd0, if_ready}, 32'd0);

    // Store, latency 3.
    p_if = n_if_rdy; p_d = n_d_rdy;
    step(); d_wr = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    step();
    @(negedge clk);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_addr", mem_addr, 32'h2000);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    @(negedge clk); chk("st_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
    step(); mem_ready = 1;
    @(negedge clk); chk("st_d_ready", {31'd0, d_ready}, 32'd1);
    step(); d_wr = 0; mem_ready = 0;
    step();
    @(negedge clk);
    chk("st_d_pulses", n_d_rdy - p_d, 32'd1);
    chk("st_if_pulses", n_if_rdy - p_if, 32'd0);

    // Read and write together: write wins.
    p_d = n_d_rdy;
    step(); d_rd = 1; d_wr = 1; d_addr = 32'h40; d_wdata = 32'h55;
    step(); mem_ready = 1;
    @(negedge clk);
    chk("rw_we", {31'd0, mem_we}, 32'd1);
    chk("rw_d_ready", {31'd0, d_ready}, 32'd1);
    step(); d_rd = 0; d_wr = 0; mem_ready = 0;
    step();
    @(negedge clk); chk("rw_d_pulses", n_d_rdy - p_d, 32'd1);

    // Build up starvation count, then reset in the 2nd cycle of a data access.
    step(); if_req = 1; d_rd = 1; d_addr = 32'h80; mem_ready = 1;
    step();
    step(); mem_ready = 0;
    step();
    p_d = n_d_rdy; p_if = n_if_rdy;
    step(); rst_n = 0; mem_ready = 1; if_req = 0; d_rd = 0;
    @(negedge clk); chk("rstm_d_ready_during", {31'd0, d_ready}, 32'd0);
    step(); rst_n = 1;
    @(negedge clk);
    chk("rstm_valid", {31'd0, mem_valid}, 32'd0);
    chk("rstm_d_ready", {31'd0, d_ready}, 32'd0);
    step();
    step();
    @(negedge clk); chk("rstm_no_pulses", (n_d_rdy - p_d) + (n_if_rdy - p_if), 32'd0);

    // Continuous contention, latency 1: starvation count must have restarted at 0.
    log_en = 1;
    step(); if_req = 1; d_rd = 1; d_addr = 32'h84; if_addr = 32'h200; mem_ready = 1;
    repeat (19) step();
    step(); if_req = 0; d_rd = 0; mem_ready = 0; log_en = 0;
    @(negedge clk);
    chk("cont_dut_grants", dut_log.size(), 32'd10);
    chk("cont_model_grants", m_log.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < dut_log.size()) chk("cont_dut_order", {31'd0, dut_log[i]}, {31'd0, exp_pat[i]});
      if (i < m_log.size()) chk("cont_model_order", {31'd0, m_log[i]}, {31'd0, exp_pat[i]});
    end
`ifdef MEM_ARB_STATS_EN
    chk("cont_stat_d", {16'd0, stat_d_grants}, 32'd8);
    chk("cont_stat_if", {16'd0, stat_if_grants}, 32'd2);
    chk("cont_stat_forced", {24'd0, stat_forced}, 32'd2);
`endif

    // Random traffic: protocol-following requesters, random memory latency.
    for (int c = 0; c < 4000; c++) begin
      int kind;
      step();
      rst_n = ($urandom_range(0, 499) != 0);
      if (saw_if_rdy) if_req = 0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (saw_d_rdy) begin d_rd = 0; d_wr = 0; end
      if (!(d_rd || d_wr) && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 2);
        d_rd = (kind != 1); d_wr = (kind != 0);
        d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end
    step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
